// File: rtl/ysyx_22050019_lsu_gen_if.sv
// Bundle of request, write-back and AXI data-side channels for the load/store unit.
// The master modport is the LSU's view; the slave modport is the pipeline/memory side.
interface ysyx_22050019_lsu_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Execute-stage request
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [4:0]            req_rd;

  // Write-back
  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_err;
  logic                  busy;

  // AXI write channels
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_size;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  // AXI read channels
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_size;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
    output req_ready, wb_valid, wb_rd, wb_data, wb_err, busy,
    output aw_valid, aw_addr, aw_size, input aw_ready,
    output w_valid, w_data, w_strb, input w_ready,
    input  b_valid, b_resp, output b_ready,
    output ar_valid, ar_addr, ar_size, input ar_ready,
    input  r_valid, r_data, r_resp, output r_ready
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
    input  req_ready, wb_valid, wb_rd, wb_data, wb_err, busy,
    input  aw_valid, aw_addr, aw_size, output aw_ready,
    input  w_valid, w_data, w_strb, output w_ready,
    output b_valid, b_resp, input b_ready,
    input  ar_valid, ar_addr, ar_size, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready
  );
endinterface

// File: rtl/ysyx_22050019_lsu_gen.sv
// Single-outstanding AXI load/store unit: lane alignment, sign/zero extension,
// misalignment trapping and response-error reporting on a one-cycle write-back pulse.
module ysyx_22050019_lsu_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_22050019_lsu_gen_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_WIDTH  = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {IDLE, RD_A, RD_R, WR_AW, WR_B, DONE} state_t;

  state_t state, state_nxt;

  // Request latched at acceptance; payloads stay stable while VALIDs are high
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [4:0]            rd_q;
  logic                  aw_done, w_done;

  logic [4:0]            wb_rd_q, wb_rd_nxt;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_nxt;
  logic                  wb_err_q, wb_err_nxt;

  logic ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic accept, req_bad;

  // Incoming-request decode
  logic [2:0]            low_mask;
  logic                  misaligned, size_illegal;
  logic [OFF_WIDTH-1:0]  req_off;
  logic [DATA_WIDTH-1:0] wdata_lane;
  logic [15:0]           strb_base, strb_wide;

  // Load-data extraction
  logic [OFF_WIDTH-1:0]  rd_off;
  logic [DATA_WIDTH-1:0] rdata_sh, load_ext;
  logic                  sign_bit;
  int                    ld_bits;

  assign accept = bus.req_valid & (state == IDLE);

  always_comb begin
    low_mask  = 3'b000;
    strb_base = 16'h0001;
    unique case (bus.req_size)
      2'd0: begin low_mask = 3'b000; strb_base = 16'h0001; end
      2'd1: begin low_mask = 3'b001; strb_base = 16'h0003; end
      2'd2: begin low_mask = 3'b011; strb_base = 16'h000F; end
      2'd3: begin low_mask = 3'b111; strb_base = 16'h00FF; end
      default: ;
    endcase
    misaligned   = |(bus.req_addr[2:0] & low_mask);
    size_illegal = (DATA_WIDTH == 32) && (bus.req_size == 2'd3);
    req_bad      = misaligned | size_illegal;
    req_off      = bus.req_addr[OFF_WIDTH-1:0];
    wdata_lane   = bus.req_wdata << {req_off, 3'b000};
    strb_wide    = strb_base << req_off;
  end

  always_comb begin
    rd_off   = addr_q[OFF_WIDTH-1:0];
    rdata_sh = bus.r_data >> {rd_off, 3'b000};
    ld_bits  = 8 << size_q;
    unique case (size_q)
      2'd0:    sign_bit = rdata_sh[7];
      2'd1:    sign_bit = rdata_sh[15];
      2'd2:    sign_bit = rdata_sh[31];
      default: sign_bit = rdata_sh[DATA_WIDTH-1];
    endcase
    // Bits above the access size are filled with the sign bit or zero
    for (int i = 0; i < DATA_WIDTH; i++)
      load_ext[i] = (i < ld_bits) ? rdata_sh[i] : (signed_q & sign_bit);
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    aw_valid    = 1'b0;
    w_valid     = 1'b0;
    b_ready     = 1'b0;
    wb_rd_nxt   = '0;
    wb_data_nxt = '0;
    wb_err_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_bad) begin
            state_nxt  = DONE;
            wb_err_nxt = 1'b1;
          end else begin
            state_nxt = bus.req_we ? WR_AW : RD_A;
          end
        end
      end
      RD_A: begin
        ar_valid = 1'b1;
        if (bus.ar_ready) state_nxt = RD_R;
      end
      RD_R: begin
        r_ready = 1'b1;
        if (bus.r_valid) begin
          state_nxt = DONE;
          if (bus.r_resp != 2'b00) begin
            wb_err_nxt = 1'b1;
          end else begin
            wb_data_nxt = load_ext;
            wb_rd_nxt   = rd_q;
          end
        end
      end
      WR_AW: begin
        // Address and data handshake independently; leave once both are complete
        aw_valid = ~aw_done;
        w_valid  = ~w_done;
        if ((aw_done | bus.aw_ready) & (w_done | bus.w_ready)) state_nxt = WR_B;
      end
      WR_B: begin
        b_ready = 1'b1;
        if (bus.b_valid) begin
          state_nxt  = DONE;
          wb_err_nxt = (bus.b_resp != 2'b00);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      rd_q     <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else if (accept) begin
      addr_q   <= bus.req_addr;
      wdata_q  <= wdata_lane;
      strb_q   <= strb_wide[STRB_WIDTH-1:0];
      size_q   <= bus.req_size;
      signed_q <= bus.req_signed;
      rd_q     <= bus.req_rd;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else if (state == WR_AW) begin
      if (aw_valid & bus.aw_ready) aw_done <= 1'b1;
      if (w_valid & bus.w_ready)   w_done  <= 1'b1;
    end
  end

  // Write-back payload is non-zero only during the DONE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      wb_rd_q   <= wb_rd_nxt;
      wb_data_q <= wb_data_nxt;
      wb_err_q  <= wb_err_nxt;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE) | accept;
  assign bus.wb_valid  = (state == DONE);
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_err    = wb_err_q;

  assign bus.ar_valid  = ar_valid;
  assign bus.ar_addr   = addr_q;
  assign bus.ar_size   = {1'b0, size_q};
  assign bus.r_ready   = r_ready;

  assign bus.aw_valid  = aw_valid;
  assign bus.aw_addr   = addr_q;
  assign bus.aw_size   = {1'b0, size_q};
  assign bus.w_valid   = w_valid;
  assign bus.w_data    = wdata_q;
  assign bus.w_strb    = strb_q;
  assign bus.b_ready   = b_ready;
endmodule
